// File: rtl/regfile_wb_sb_if.sv
// regfile_wb_sb_if: write-back, read and issue signals between the pipeline and the register file
interface regfile_wb_sb_if #(parameter int DATA_W = 32, parameter int NREG = 32);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              stall;
  logic [CW-1:0]     pend_cnt;
  modport master (
    output wb_en, wb_addr, wb_data, rs_addr, rt_addr, rs_used, rt_used, issue_valid, issue_rd,
    input  rs_data, rt_data, rs_busy, rt_busy, stall, pend_cnt
  );
  modport slave (
    input  wb_en, wb_addr, wb_data, rs_addr, rt_addr, rs_used, rt_used, issue_valid, issue_rd,
    output rs_data, rt_data, rs_busy, rt_busy, stall, pend_cnt
  );
endinterface

// File: rtl/regfile_wb_sb.sv
// regfile_wb_sb: MIPS register file with write-through bypass, hardwired $0 and pending-write scoreboard
module regfile_wb_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input logic             clk,
  input logic             rst_n,
  regfile_wb_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [CW-1:0]     r_pend;
  logic [NREG-1:0]   w_busy_nxt;
  logic [CW-1:0]     w_pend_nxt;
  logic              w_wb, w_rs_hit, w_rt_hit, w_rs_busy, w_rt_busy, w_stall, w_iss;
  // bypass is suppressed in reset so every output reads 0 while rst_n is low
  assign w_wb      = bus.wb_en & rst_n;
  assign w_rs_hit  = w_wb && bus.wb_addr == bus.rs_addr;
  assign w_rt_hit  = w_wb && bus.wb_addr == bus.rt_addr;
  assign w_rs_busy = r_busy[bus.rs_addr] & ~w_rs_hit;
  assign w_rt_busy = r_busy[bus.rt_addr] & ~w_rt_hit;
  assign w_stall   = (w_rs_busy & bus.rs_used) | (w_rt_busy & bus.rt_used);
  assign w_iss     = bus.issue_valid & ~w_stall & (bus.issue_rd != '0);
  assign bus.rs_data  = bus.rs_addr == '0 ? '0 : w_rs_hit ? bus.wb_data : r_regs[bus.rs_addr];
  assign bus.rt_data  = bus.rt_addr == '0 ? '0 : w_rt_hit ? bus.wb_data : r_regs[bus.rt_addr];
  assign bus.rs_busy  = w_rs_busy;
  assign bus.rt_busy  = w_rt_busy;
  assign bus.stall    = w_stall;
  assign bus.pend_cnt = r_pend;
  // next scoreboard state: a new issue owns the register even if its old write-back lands now
  always_comb begin
    w_busy_nxt = '0;
    w_pend_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      w_busy_nxt[i] = (w_iss && bus.issue_rd == AW'(i)) | (r_busy[i] & ~(w_wb && bus.wb_addr == AW'(i)));
      w_pend_nxt    = w_pend_nxt + CW'(w_busy_nxt[i]);
    end
  end
  // register storage; entry 0 is never written and never read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb && bus.wb_addr != '0) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end
  // scoreboard and its population count advance together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_pend <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_pend <= w_pend_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_sb.sv
// tb_regfile_wb_sb: directed stimulus against a behavioural register-file/scoreboard model
module tb_regfile_wb_sb;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_reg [32];
  logic        m_busy [32];
  regfile_wb_sb_if #(.DATA_W(32), .NREG(32)) bus ();
  regfile_wb_sb #(.DATA_W(32), .NREG(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] exp_data(logic [4:0] a);
    if (a == 0) return 0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_reg[a];
  endfunction
  function automatic logic exp_busy(logic [4:0] a);
    return m_busy[a] && !(bus.wb_en && bus.wb_addr == a);
  endfunction
  function automatic logic exp_stall();
    return (exp_busy(bus.rs_addr) && bus.rs_used) || (exp_busy(bus.rt_addr) && bus.rt_used);
  endfunction
  function automatic logic [31:0] exp_pend();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 32'(c);
  endfunction
  // reference model: architectural registers plus a set of registers with an outstanding producer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 0;
        m_busy[i] = 0;
      end
    end else begin
      logic st;
      st = exp_stall();
      if (bus.wb_en && bus.wb_addr != 0) m_reg[bus.wb_addr] = bus.wb_data;
      if (bus.wb_en) m_busy[bus.wb_addr] = 0;
      if (bus.issue_valid && !st && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
    end
  end
  // every out-of-reset cycle, all outputs must match the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rs_data", bus.rs_data, exp_data(bus.rs_addr));
      chk("rt_data", bus.rt_data, exp_data(bus.rt_addr));
      chk("rs_busy", 32'(bus.rs_busy), 32'(exp_busy(bus.rs_addr)));
      chk("rt_busy", 32'(bus.rt_busy), 32'(exp_busy(bus.rt_addr)));
      chk("stall", 32'(bus.stall), 32'(exp_stall()));
      chk("pend_cnt", 32'(bus.pend_cnt), exp_pend());
    end
  end
  task automatic idle();
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.rs_addr = 0; bus.rt_addr = 0; bus.rs_used = 0; bus.rt_used = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(logic [4:0] a, logic [31:0] d);
    bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
  endtask
  task automatic issue(logic [4:0] rd);
    bus.issue_valid = 1; bus.issue_rd = rd;
  endtask
  task automatic zero_chk(string tag);
    chk({tag, "_rs_data"}, bus.rs_data, 0);
    chk({tag, "_rt_data"}, bus.rt_data, 0);
    chk({tag, "_rs_busy"}, 32'(bus.rs_busy), 0);
    chk({tag, "_rt_busy"}, 32'(bus.rt_busy), 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
    chk({tag, "_pend"}, 32'(bus.pend_cnt), 0);
  endtask
  initial begin
    idle();
    bus.rs_addr = 5; bus.rt_addr = 31; bus.rs_used = 1; bus.rt_used = 1;
    wb(31, 32'hCAFEF00D);
    repeat (2) tick();
    #2 zero_chk("rst_hold");
    idle();
    rst_n = 1;
    tick();
    bus.rs_addr = 5; bus.rt_addr = 31;
    #2 chk("post_rst_rs", bus.rs_data, 0);
    chk("post_rst_stall", 32'(bus.stall), 0);
    chk("post_rst_pend", 32'(bus.pend_cnt), 0);
    tick(); idle();
    wb(0, 32'hDEADBEEF);
    #2 chk("r0_same_cycle", bus.rs_data, 0);
    tick(); idle();
    #2 chk("r0_after", bus.rs_data, 0);
    tick();
    wb(5, 32'h12345678); bus.rs_addr = 5; bus.rt_addr = 5;
    #2 chk("byp_rs", bus.rs_data, 32'h12345678);
    chk("byp_rt", bus.rt_data, 32'h12345678);
    tick(); bus.wb_en = 0;
    #2 chk("stor_rs", bus.rs_data, 32'h12345678);
    chk("stor_rt", bus.rt_data, 32'h12345678);
    tick(); idle(); wb(7, 32'hA);
    tick(); wb(7, 32'hB);
    tick(); idle(); bus.rs_addr = 7;
    #2 chk("r7_last", bus.rs_data, 32'hB);
    tick(); idle(); issue(9);
    tick(); idle(); bus.rs_addr = 9; bus.rs_used = 1;
    #2 chk("sb_stall", 32'(bus.stall), 1);
    chk("sb_pend1", 32'(bus.pend_cnt), 1);
    bus.rs_used = 0;
    #1 chk("sb_unused", 32'(bus.stall), 0);
    bus.rs_used = 1; wb(9, 32'h55);
    #1 chk("sb_wb_stall", 32'(bus.stall), 0);
    chk("sb_wb_data", bus.rs_data, 32'h55);
    tick(); idle(); bus.rs_addr = 9; bus.rs_used = 1;
    #2 chk("sb_clr_busy", 32'(bus.rs_busy), 0);
    chk("sb_clr_pend", 32'(bus.pend_cnt), 0);
    tick(); idle(); issue(3);
    tick(); idle(); wb(3, 32'h33); issue(3);
    #2 chk("coll_pend_before", 32'(bus.pend_cnt), 1);
    tick(); idle(); bus.rs_addr = 3; bus.rs_used = 1;
    #2 chk("coll_busy", 32'(bus.rs_busy), 1);
    chk("coll_pend", 32'(bus.pend_cnt), 1);
    chk("coll_data", bus.rs_data, 32'h33);
    wb(3, 32'h44);
    #1 chk("coll_byp", bus.rs_data, 32'h44);
    tick(); idle();
    #2 chk("coll_clr_pend", 32'(bus.pend_cnt), 0);
    tick(); issue(8);
    tick(); idle(); bus.rs_addr = 8; bus.rs_used = 1; issue(4);
    #2 chk("gate_stall", 32'(bus.stall), 1);
    tick(); idle(); bus.rt_addr = 4; bus.rt_used = 1;
    #2 chk("gate_busy4", 32'(bus.rt_busy), 0);
    chk("gate_pend", 32'(bus.pend_cnt), 1);
    wb(8, 32'h88);
    tick(); idle();
    #2 chk("gate_clr_pend", 32'(bus.pend_cnt), 0);
    for (int i = 1; i < 32; i++) begin
      tick(); idle(); issue(5'(i));
    end
    tick(); idle();
    #2 chk("all_pend31", 32'(bus.pend_cnt), 31);
    wb(10, 32'h1010);
    tick(); idle();
    #2 chk("all_pend30", 32'(bus.pend_cnt), 30);
    bus.rs_addr = 31; bus.rt_addr = 20; bus.rs_used = 1; bus.rt_used = 1;
    wb(31, 32'hFFFF0000);
    #1 rst_n = 0;
    #1 zero_chk("rst_mid");
    idle();
    tick();
    rst_n = 1;
    tick(); bus.rs_addr = 20; bus.rt_addr = 5;
    #2 chk("rst_mid_after_rs", bus.rs_data, 0);
    chk("rst_mid_after_rt", bus.rt_data, 0);
    chk("rst_mid_after_pend", 32'(bus.pend_cnt), 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
